// File: rtl/uart_pkg.sv
// Shared types and frame-layout constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int FRAME_W     = 11;
    localparam int FR_START    = 10;
    localparam int FR_DATA_MSB = 9;
    localparam int FR_DATA_LSB = 2;
    localparam int FR_PAR      = 1;
    localparam int FR_STOP     = 0;

    localparam logic [1:0] PARITY_NONE = 2'b11;

    // Frame slot carrying the data bit numbered bit_cnt (0 = first bit sent).
    function automatic logic [3:0] data_slot(input logic eight_bits, input logic [2:0] bit_cnt);
        logic [3:0] first_slot;
        first_slot = eight_bits ? 4'(FR_DATA_MSB) : 4'(FR_DATA_MSB - 1);
        return first_slot - {1'b0, bit_cnt};
    endfunction

    function automatic logic [2:0] last_data_cnt(input logic eight_bits);
        return eight_bits ? 3'd7 : 3'd6;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle and the cycle before it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_tick_o,
    output logic pre_tick_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at zero while cleared, wraps at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = !clear_i && (cnt_q == LAST_CNT);
    assign pre_tick_o = !clear_i && (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: latches a frame on request and shifts start/data/parity/stop onto tx_out.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               data_length,
    input  logic [1:0]         parity_type,
    input  logic               stop_bits,
    output logic               tx_out,
    output logic               busy,
    output logic               done
);

    state_e                    state_q, state_d;
    logic [FR_DATA_MSB:FR_PAR] slots_q, slots_d;
    logic                      len8_q, len8_d;
    logic                      par_en_q, par_en_d;
    logic                      two_stop_q, two_stop_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      stop2_q, stop2_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      clr_s;
    logic                      tick_s;
    logic                      pre_tick_s;
    logic                      last_stop_s;
    logic                      unused_stop_s;

    // The stop slot is implied: the line is always driven high for stop bits.
    assign unused_stop_s = frame_in[FR_STOP];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clr_s),
        .bit_tick_o(tick_s),
        .pre_tick_o(pre_tick_s)
    );

    assign last_stop_s = !two_stop_q || stop2_q;

    // Next-state and next-output logic; tx/busy/done are computed one cycle ahead and registered.
    always_comb begin
        state_d    = state_q;
        slots_d    = slots_q;
        len8_d     = len8_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        bit_cnt_d  = bit_cnt_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        clr_s      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                clr_s  = 1'b1;
                if (tx_start) begin
                    state_d    = START;
                    slots_d    = frame_in[FR_DATA_MSB:FR_PAR];
                    len8_d     = data_length;
                    par_en_d   = (parity_type != PARITY_NONE);
                    two_stop_d = stop_bits;
                    bit_cnt_d  = 3'd0;
                    stop2_d    = 1'b0;
                    tx_d       = frame_in[FR_START];
                    busy_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = slots_q[data_slot(len8_q, 3'd0)];
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_cnt_q == last_data_cnt(len8_q)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = slots_q[FR_PAR];
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = slots_q[data_slot(len8_q, bit_cnt_q + 3'd1)];
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                // done must be high during the wrap cycle, so it is registered from the cycle before.
                done_d = last_stop_s && pre_tick_s;
                if (tick_s) begin
                    if (last_stop_s) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop2_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, shadow configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slots_q    <= '0;
            len8_q     <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slots_q    <= slots_d;
            len8_q     <= len8_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle line/busy/done compared against a bit-list frame model.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start2;
    logic [10:0] frame;
    logic        dl;
    logic [1:0]  pt;
    logic        sb;
    logic        tx4, busy4, done4;
    logic        tx2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_v [0:255];
    logic [2:0] obs_v [0:255];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .tx_start(start4), .frame_in(frame),
        .data_length(dl), .parity_type(pt), .stop_bits(sb),
        .tx_out(tx4), .busy(busy4), .done(done4)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .tx_start(start2), .frame_in(frame),
        .data_length(dl), .parity_type(pt), .stop_bits(sb),
        .tx_out(tx2), .busy(busy2), .done(done2)
    );

    // Model: list of line bits for the frame, each held cpb cycles; entry = {tx, busy, done}.
    function automatic int add_frame(int off, logic [10:0] f, logic d8, logic [1:0] p, logic s2, int cpb);
        bit q[$];
        int n;
        q.push_back(f[10]);
        for (int k = 9; k >= 2; k--) begin
            if (k != 9 || d8) q.push_back(f[k]);
        end
        if (p != 2'b11) q.push_back(f[1]);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        n = q.size() * cpb;
        for (int i = 0; i < n; i++) exp_v[off + i] = {q[i / cpb], 1'b1, (i == n - 1)};
        exp_v[off + n] = 3'b100;
        return n;
    endfunction

    // Pulse start on the selected DUT and record ncyc cycles starting with the first cycle after acceptance.
    task automatic capture(input bit sel, input int ncyc, input int hold, input bit mutate);
        if (sel) start2 = 1'b1; else start4 = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            obs_v[i] = sel ? {tx2, busy2, done2} : {tx4, busy4, done4};
            if (i >= hold) begin
                start4 = 1'b0;
                start2 = 1'b0;
            end
            if (mutate) begin
                frame = 11'($urandom);
                dl    = 1'($urandom);
                pt    = 2'($urandom);
                sb    = 1'($urandom);
            end
        end
        start4 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
        frame = 11'h7ff; dl = 1'b1; pt = 2'b00; sb = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tx4, busy4, done4, tx2, busy2, done2} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 100100", {tx4, busy4, done4, tx2, busy2, done2});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tx4, busy4, done4} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 100", {tx4, busy4, done4});
        end
    endtask

    task automatic test_plan_a();
        int n, bc;
        frame = 11'b0_10110010_1_1; dl = 1'b1; pt = 2'b00; sb = 1'b0;
        n = add_frame(0, frame, dl, pt, sb, 4);
        capture(1'b0, n + 1, 0, 1'b0);
        bc = 0;
        for (int i = 0; i <= n; i++) begin
            bc += int'(obs_v[i][1]);
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL plan_a cyc %0d: got tx/busy/done %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        n_tests++;
        if (bc != 44 || obs_v[43][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL plan_a_busy_len: got %0d busy cycles, done@44=%b expected 44 and 1", bc, obs_v[43][0]);
        end
    endtask

    task automatic test_plan_b();
        int n, bc;
        frame = 11'b0_10110010_1_1; dl = 1'b0; pt = 2'b11; sb = 1'b1;
        n = add_frame(0, frame, dl, pt, sb, 4);
        capture(1'b0, n + 1, 0, 1'b0);
        bc = 0;
        for (int i = 0; i <= n; i++) begin
            bc += int'(obs_v[i][1]);
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL plan_b cyc %0d: got tx/busy/done %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        n_tests++;
        if (bc != 40) begin
            n_fail++;
            $display("FAIL plan_b_busy_len: got %0d busy cycles expected 40", bc);
        end
    endtask

    task automatic test_random();
        int n;
        bit sel;
        for (int t = 0; t < 8; t++) begin
            frame = 11'($urandom); dl = 1'($urandom); pt = 2'($urandom); sb = 1'($urandom);
            sel = 1'($urandom);
            n = add_frame(0, frame, dl, pt, sb, sel ? 2 : 4);
            capture(sel, n + 1, 0, 1'b0);
            for (int i = 0; i <= n; i++) begin
                n_tests++;
                if (obs_v[i] !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL random t%0d cyc %0d: got %b expected %b", t, i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, n2;
        frame = 11'($urandom); dl = 1'($urandom); pt = 2'($urandom); sb = 1'($urandom);
        n  = add_frame(0, frame, dl, pt, sb, 4);
        n2 = add_frame(n + 1, frame, dl, pt, sb, 4);
        capture(1'b0, n + n2 + 2, n + 1, 1'b0);
        for (int i = 0; i <= n + n2 + 1; i++) begin
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_mid_change();
        int n;
        frame = 11'b0_01101001_0_1; dl = 1'b1; pt = 2'b01; sb = 1'b0;
        n = add_frame(0, frame, dl, pt, sb, 4);
        capture(1'b0, n + 1, 0, 1'b1);
        for (int i = 0; i <= n; i++) begin
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL mid_change cyc %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        frame = 11'b0_00000000_0_1; dl = 1'b1; pt = 2'b00; sb = 1'b1;
        n = add_frame(0, frame, dl, pt, sb, 4);
        capture(1'b0, 18, 0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({tx4, busy4, done4} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 100", {tx4, busy4, done4});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3 * 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({tx4, busy4, done4} !== 3'b100) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc %0d: got %b expected 100", i, {tx4, busy4, done4});
            end
        end
        frame = 11'($urandom); dl = 1'($urandom); pt = 2'($urandom); sb = 1'($urandom);
        n = add_frame(0, frame, dl, pt, sb, 4);
        capture(1'b0, n + 1, 0, 1'b0);
        for (int i = 0; i <= n; i++) begin
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL after_reset cyc %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_min_cpb();
        int n, bc;
        frame = {1'b0, 8'($urandom), 1'($urandom), 1'b1}; dl = 1'b1; pt = 2'b01; sb = 1'b1;
        n = add_frame(0, frame, dl, pt, sb, 2);
        capture(1'b1, n + 1, 0, 1'b0);
        bc = 0;
        for (int i = 0; i <= n; i++) begin
            bc += int'(obs_v[i][1]);
            n_tests++;
            if (obs_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL min_cpb cyc %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        n_tests++;
        if (bc != 24) begin
            n_fail++;
            $display("FAIL min_cpb_busy_len: got %0d busy cycles expected 24", bc);
        end
    endtask

    initial begin
        test_reset();
        test_plan_a();
        test_plan_b();
        test_random();
        test_back_to_back();
        test_mid_change();
        test_reset_mid();
        test_min_cpb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
